// File: rtl/alu_result_display.sv
// Captures an 8-bit ALU result plus carry and converts it to BCD, one bit per cycle.
// It then drives a 4-digit active-low 7-seg display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module alu_result_display #(
    parameter int REFRESH_CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result_in,
    input  logic       carry_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  it_q, it_d;
    logic        pcarry_q, pcarry_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic        dcarry_q, dcarry_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [REFRESH_CNT_W-1:0] cnt_q;

    logic [11:0] bcd_adj;
    logic [19:0] shifted;
    logic [1:0]  sel;
    logic        blank_h, blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step: correct every nibble, then shift the whole chain.
    always_comb begin
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shifted = {bcd_adj, sr_q} << 1;
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        it_d     = it_q;
        pcarry_d = pcarry_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        dcarry_d = dcarry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d     = result_in;
                    pcarry_d = carry_in;
                    bcd_d    = '0;
                    it_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bcd_d = shifted[19:8];
                sr_d  = shifted[7:0];
                it_d  = it_q + 3'd1;
                if (it_q == 3'd7) begin
                    hund_d   = shifted[19:16];
                    tens_d   = shifted[15:12];
                    ones_d   = shifted[11:8];
                    dcarry_d = pcarry_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bcd_q    <= '0;
            it_q     <= '0;
            pcarry_q <= 1'b0;
            hund_q   <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            dcarry_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            it_q     <= it_d;
            pcarry_q <= pcarry_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            dcarry_q <= dcarry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_q + {{(REFRESH_CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (hund_q == 4'd0);
    assign blank_t = blank_h && (tens_q == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    assign sel = cnt_q[REFRESH_CNT_W-1 -: 2];

    always_comb begin
        seg = 7'b1111111;
        case (sel)
            2'd0: seg = dec7(ones_q);
            2'd1: seg = blank_t ? 7'b1111111 : dec7(tens_q);
            2'd2: seg = blank_h ? 7'b1111111 : dec7(hund_q);
            2'd3: seg = dcarry_q ? 7'b1000110 : 7'b1111111;
            default: seg = 7'b1111111;
        endcase
    end

    assign an   = ~(4'b0001 << sel);
    assign dp   = 1'b1;
    assign busy = busy_q;
    assign done = done_q;

endmodule
